// File: rtl/lcd_ctrl.sv
// HD44780 8-bit write-only bus controller. Converts strobe toggles from the LSU
// LCD register into timed RS/DATA/EN write cycles with a one-deep request buffer.
module lcd_ctrl #(
   parameter int CNT_W   = 20,
   parameter int T_PWRUP = 750000,
   parameter int T_SETUP = 2,
   parameter int T_EN    = 12,
   parameter int T_HOLD  = 2,
   parameter int T_EXEC  = 2000,
   parameter int T_CLR   = 82000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_io_lcd,
   output logic [7:0]  o_lcd_data,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic        o_lcd_en,
   output logic        o_lcd_on,
   output logic        o_busy,
   output logic        o_ovf
);

   typedef enum logic [2:0] {
      S_PWRUP, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC
   } state_t;

   localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);
   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tog_q, tog_d;
   logic [8:0]       pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic [7:0]       data_q, data_d;
   logic             rs_q, rs_d;
   logic             en_q, en_d;
   logic             on_q, on_d;
   logic             busy_q, busy_d;
   logic             ovf_q, ovf_d;

   logic cnt_zero, launch, req, slot_free, ovf_set, is_clr;
   logic unused_bits;

   assign unused_bits = ^i_io_lcd[30:11];

   assign cnt_zero  = (cnt_q == '0);
   assign launch    = (state_q == S_IDLE) && pend_vld_q;
   assign req       = i_io_lcd[9] ^ tog_q;
   assign slot_free = !pend_vld_q || launch;
   assign ovf_set   = req && !slot_free;
   // Clear/home commands need the long execution wait
   assign is_clr    = !rs_q && (data_q inside {8'h01, 8'h02, 8'h03});

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_zero ? cnt_q : cnt_q - 1'b1;
      rs_d       = rs_q;
      data_d     = data_q;
      en_d       = en_q;
      tog_d      = i_io_lcd[9];
      pend_d     = pend_q;
      pend_vld_d = launch ? 1'b0 : pend_vld_q;
      on_d       = i_io_lcd[31];

      case (state_q)
         S_PWRUP: if (cnt_zero) state_d = S_IDLE;
         S_IDLE: if (pend_vld_q) begin
            state_d = S_SETUP;
            rs_d    = pend_q[8];
            data_d  = pend_q[7:0];
            cnt_d   = LD_SETUP;
         end
         S_SETUP: if (cnt_zero) begin
            state_d = S_PULSE;
            cnt_d   = LD_EN;
            en_d    = 1'b1;
         end
         S_PULSE: if (cnt_zero) begin
            state_d = S_HOLD;
            cnt_d   = LD_HOLD;
            en_d    = 1'b0;
         end
         S_HOLD: if (cnt_zero) begin
            state_d = S_EXEC;
            cnt_d   = is_clr ? LD_CLR : LD_EXEC;
         end
         S_EXEC: if (cnt_zero) state_d = S_IDLE;
         default: state_d = S_PWRUP;
      endcase

      if (req && slot_free) begin
         pend_d     = i_io_lcd[8:0];
         pend_vld_d = 1'b1;
      end

      if (ovf_set)          ovf_d = 1'b1;
      else if (i_io_lcd[10]) ovf_d = 1'b0;
      else                  ovf_d = ovf_q;

      busy_d = (state_d != S_IDLE) || pend_vld_d;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_PWRUP;
         cnt_q      <= LD_PWRUP;
         tog_q      <= 1'b0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         rs_q       <= 1'b0;
         data_q     <= '0;
         en_q       <= 1'b0;
         on_q       <= 1'b0;
         busy_q     <= 1'b1;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tog_q      <= tog_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         rs_q       <= rs_d;
         data_q     <= data_d;
         en_q       <= en_d;
         on_q       <= on_d;
         busy_q     <= busy_d;
         ovf_q      <= ovf_d;
      end
   end

   assign o_lcd_data = data_q;
   assign o_lcd_rs   = rs_q;
   assign o_lcd_rw   = 1'b0;
   assign o_lcd_en   = en_q;
   assign o_lcd_on   = on_q;
   assign o_busy     = busy_q;
   assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing parameters.
module tb_lcd_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] io_lcd = '0;
   logic [7:0]  lcd_data;
   logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy, ovf;

   int checks = 0;
   int failures = 0;

   lcd_ctrl #(
      .CNT_W(8), .T_PWRUP(10), .T_SETUP(2), .T_EN(4),
      .T_HOLD(2), .T_EXEC(20), .T_CLR(50)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_io_lcd(io_lcd),
      .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
      .o_lcd_en(lcd_en), .o_lcd_on(lcd_on), .o_busy(busy), .o_ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic toggle(input logic rs, input logic [7:0] d);
      io_lcd[9]   = ~io_lcd[9];
      io_lcd[8]   = rs;
      io_lcd[7:0] = d;
      tick();
   endtask

   task automatic wait_en(input logic lvl, input int max, output int n);
      n = 0;
      while (lcd_en !== lvl && n < max) begin
         n++;
         tick();
      end
   endtask

   // Count cycles busy stays high, starting at the current sample
   task automatic busy_len(input int max, output int n, output int en_seen);
      n = 0;
      en_seen = 0;
      while (busy === 1'b1 && n < max) begin
         if (lcd_en !== 1'b0) en_seen++;
         n++;
         tick();
      end
   endtask

   task automatic quiet(input int cyc, output int en_seen, output int busy_seen);
      en_seen = 0;
      busy_seen = 0;
      for (int i = 0; i < cyc; i++) begin
         if (lcd_en !== 1'b0) en_seen++;
         if (busy !== 1'b0) busy_seen++;
         tick();
      end
   endtask

   // Write with EN pulse width and EXEC length measured
   task automatic do_write(input string tag, input logic rs, input logic [7:0] d,
                           input int exec_exp);
      int n, e;
      toggle(rs, d);
      check({tag, "_busy_req"}, busy, 1);
      tick();
      check({tag, "_rs"}, lcd_rs, rs);
      check({tag, "_data"}, lcd_data, d);
      check({tag, "_en_setup"}, lcd_en, 0);
      wait_en(1'b1, 10, n);
      check({tag, "_en_rise"}, n, 2);
      wait_en(1'b0, 10, n);
      check({tag, "_en_width"}, n, 4);
      check({tag, "_data_held"}, lcd_data, d);
      tick();
      tick();
      busy_len(200, n, e);
      check({tag, "_exec_len"}, n, exec_exp);
      check({tag, "_exec_en"}, e, 0);
   endtask

   initial begin
      int n, e, b;

      // 1. reset and power-up wait
      io_lcd = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_busy", busy, 1);
      check("rst_en", lcd_en, 0);
      check("rst_outs", {lcd_data, lcd_rs, lcd_rw, lcd_on, ovf}, 0);
      busy_len(40, n, e);
      check("pwrup_len", n, 10);
      check("pwrup_en", e, 0);
      check("idle_outs", {lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, ovf}, 0);

      // 2./3. single writes, normal and clear timing
      do_write("w41", 1'b1, 8'h41, 20);
      do_write("clr", 1'b0, 8'h01, 50);
      do_write("fset", 1'b0, 8'h38, 20);

      // 4. overflow inside one write
      toggle(1'b1, 8'h41);
      tick();
      toggle(1'b1, 8'h42);
      toggle(1'b1, 8'h43);
      check("ovf_set", ovf, 1);
      wait_en(1'b1, 20, n);
      check("ovf_w1_data", lcd_data, 8'h41);
      wait_en(1'b0, 10, n);
      wait_en(1'b1, 100, n);
      check("ovf_w2_gap", n, 25);
      check("ovf_w2_data", lcd_data, 8'h42);
      wait_en(1'b0, 10, n);
      busy_len(100, n, e);
      quiet(30, e, b);
      check("ovf_no_w3", e, 0);
      check("ovf_idle", b, 0);
      check("ovf_sticky", ovf, 1);
      io_lcd[10] = 1'b1;
      tick();
      io_lcd[10] = 1'b0;
      check("ovf_clr", ovf, 0);
      io_lcd[31] = 1'b1;
      tick();
      check("lcd_on", lcd_on, 1);

      // 5. requests during power-up
      io_lcd = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_on", lcd_on, 0);
      toggle(1'b1, 8'h50);
      toggle(1'b1, 8'h51);
      check("pw_ovf", ovf, 1);
      wait_en(1'b1, 40, n);
      check("pw_en_rise", n, 11);
      check("pw_data", {lcd_rs, lcd_data}, {1'b1, 8'h50});
      wait_en(1'b0, 10, n);
      busy_len(100, n, e);
      quiet(30, e, b);
      check("pw_no_w2", e, 0);

      // 6. reset while EN high with a pending request
      toggle(1'b1, 8'h60);
      tick();
      toggle(1'b1, 8'h61);
      wait_en(1'b1, 20, n);
      check("r6_en_hi", lcd_en, 1);
      rst = 1'b1;
      io_lcd = '0;
      tick();
      rst = 1'b0;
      check("r6_en", lcd_en, 0);
      check("r6_busy", busy, 1);
      check("r6_outs", {lcd_data, lcd_rs, ovf}, 0);
      busy_len(40, n, e);
      check("r6_pwrup_len", n, 10);
      check("r6_pwrup_en", e, 0);
      quiet(30, e, b);
      check("r6_no_write", e, 0);
      check("r6_idle", b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
